// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the ALU control stage: ALUOp, funct and ALUOperation encodings,
// the mul/div operation encoding and the mul/div sequencer state type.
package alu_ctrl_pkg;

  localparam logic [2:0] ALUOP_ANDI  = 3'b001;
  localparam logic [2:0] ALUOP_SW    = 3'b010;
  localparam logic [2:0] ALUOP_LUI   = 3'b011;
  localparam logic [2:0] ALUOP_ORI   = 3'b101;
  localparam logic [2:0] ALUOP_ADDI  = 3'b110;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    OP_AND     = 4'b0000,
    OP_OR      = 4'b0001,
    OP_NOR     = 4'b0010,
    OP_ADD     = 4'b0011,
    OP_SUB     = 4'b0100,
    OP_LUI     = 4'b0101,
    OP_SRL     = 4'b0110,
    OP_SLL     = 4'b0111,
    OP_ILLEGAL = 4'b1001,
    OP_MULT    = 4'b1010,
    OP_MULTU   = 4'b1011,
    OP_DIV     = 4'b1100,
    OP_DIVU    = 4'b1101
  } alu_oper_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/alu_control_mc_if.sv
// Decode-side / EX-side handshake plus mul/div sequencing signals of alu_control_mc.
// slave is the control stage itself; master is its environment.
interface alu_control_mc_if;

  logic       id_valid;
  logic       id_ready;
  logic [2:0] alu_op;
  logic [5:0] alu_function;
  logic       ex_ready;
  logic       ex_valid;
  logic [3:0] alu_operation;
  logic       illegal;
  logic       md_start;
  logic [1:0] md_op;
  logic       md_busy;
  logic       md_done;

  modport slave (
    input  id_valid, alu_op, alu_function, ex_ready,
    output id_ready, ex_valid, alu_operation, illegal,
           md_start, md_op, md_busy, md_done
  );

  modport master (
    output id_valid, alu_op, alu_function, ex_ready,
    input  id_ready, ex_valid, alu_operation, illegal,
           md_start, md_op, md_busy, md_done
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decoder. MULT/MULTU/DIV/DIVU decode as mul/div ops only
// when ALU_MULDIV_EN is defined; otherwise they fall into the illegal code.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic [5:0] alu_function_i,
  output alu_oper_e  operation_o,
  output logic       illegal_o,
  output logic       is_md_o,
  output md_op_e     md_op_o
);

  always_comb begin
    // NOTE: every output is given a default first so no path through the case infers a latch.
    operation_o = OP_ILLEGAL;
    illegal_o   = 1'b1;
    is_md_o     = 1'b0;
    md_op_o     = MD_MULT;
    case (alu_op_i)
      ALUOP_RTYPE: begin
        illegal_o = 1'b0;
        case (alu_function_i)
          FN_AND: operation_o = OP_AND;
          FN_OR:  operation_o = OP_OR;
          FN_NOR: operation_o = OP_NOR;
          FN_ADD: operation_o = OP_ADD;
          FN_SUB: operation_o = OP_SUB;
          FN_SRL: operation_o = OP_SRL;
          FN_SLL: operation_o = OP_SLL;
`ifdef ALU_MULDIV_EN
          FN_MULT: begin
            operation_o = OP_MULT;
            is_md_o     = 1'b1;
            md_op_o     = MD_MULT;
          end
          FN_MULTU: begin
            operation_o = OP_MULTU;
            is_md_o     = 1'b1;
            md_op_o     = MD_MULTU;
          end
          FN_DIV: begin
            operation_o = OP_DIV;
            is_md_o     = 1'b1;
            md_op_o     = MD_DIV;
          end
          FN_DIVU: begin
            operation_o = OP_DIVU;
            is_md_o     = 1'b1;
            md_op_o     = MD_DIVU;
          end
`else
          // Without the mul/div datapath these functs are reported as illegal.
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: illegal_o = 1'b1;
`endif
          default: illegal_o = 1'b1;
        endcase
      end
      ALUOP_ANDI: begin
        operation_o = OP_AND;
        illegal_o   = 1'b0;
      end
      ALUOP_ADDI, ALUOP_SW: begin
        operation_o = OP_ADD;
        illegal_o   = 1'b0;
      end
      ALUOP_ORI: begin
        operation_o = OP_OR;
        illegal_o   = 1'b0;
      end
      ALUOP_LUI: begin
        operation_o = OP_LUI;
        illegal_o   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_control_mc.sv
// Registered ALU control stage with valid/ready handshake and a fixed-latency mul/div
// sequencer. The sequencer exists only when ALU_MULDIV_EN is defined.
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 33
) (
  input logic             clk,
  input logic             reset,
  alu_control_mc_if.slave bus
);

  if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_latency
    $error("alu_control_mc: MUL_CYCLES and DIV_CYCLES must be at least 1");
  end

  alu_oper_e dec_operation;
  logic      dec_illegal;
  logic      dec_is_md;
  md_op_e    dec_md_op;
  logic      transfer;

  logic       ex_valid_q;
  logic [3:0] alu_operation_q;
  logic       illegal_q;

  alu_ctrl_decode u_decode (
    .alu_op_i       (bus.alu_op),
    .alu_function_i (bus.alu_function),
    .operation_o    (dec_operation),
    .illegal_o      (dec_illegal),
    .is_md_o        (dec_is_md),
    .md_op_o        (dec_md_op)
  );

  assign transfer = bus.id_valid && bus.id_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q      <= 1'b0;
      alu_operation_q <= OP_ILLEGAL;
      illegal_q       <= 1'b0;
    end else if (bus.ex_ready) begin
      ex_valid_q <= transfer;
      if (transfer) begin
        alu_operation_q <= dec_operation;
        illegal_q       <= dec_illegal;
      end
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.alu_operation = alu_operation_q;
  assign bus.illegal       = illegal_q;

`ifdef ALU_MULDIV_EN
  localparam int CNT_W = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           md_op_q, md_op_d;
  logic             md_start_q, md_start_d;
  logic             md_busy;

  assign md_busy      = (state_q == ST_RUN);
  assign bus.id_ready = bus.ex_ready && !md_busy;

  // Transfers only happen in IDLE because id_ready is low throughout RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_op_d    = md_op_q;
    md_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (transfer && dec_is_md) begin
          state_d    = ST_RUN;
          md_start_d = 1'b1;
          md_op_d    = dec_md_op;
          cnt_d      = (dec_md_op inside {MD_DIV, MD_DIVU}) ? DIV_LAST : MUL_LAST;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      md_op_q    <= MD_MULT;
      md_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_op_q    <= md_op_d;
      md_start_q <= md_start_d;
    end
  end

  assign bus.md_start = md_start_q;
  assign bus.md_op    = md_op_q;
  assign bus.md_busy  = md_busy;
  assign bus.md_done  = md_busy && (cnt_q == '0);
`else
  logic unused_md;
  assign unused_md = ^{dec_is_md, dec_md_op};

  assign bus.id_ready = bus.ex_ready;
  assign bus.md_start = 1'b0;
  assign bus.md_op    = 2'b00;
  assign bus.md_busy  = 1'b0;
  assign bus.md_done  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc: a table-driven reference model compared every
// cycle, plus directed vectors with literal expectations. Follows ALU_MULDIV_EN.
module tb_alu_control_mc;

  localparam int MUL_L = 4;
  localparam int DIV_L = 33;

  typedef struct {
    logic [2:0] aop;
    logic       any_fn;
    logic [5:0] fn;
    logic [3:0] code;
    logic       md;
    logic [1:0] mop;
  } dec_row_t;

  typedef struct {
    logic [2:0] aop;
    logic [5:0] fn;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_fail = 0;

  dec_row_t rows[$];
  vec_t     sweep[$];

  // Reference model state: registered outputs and remaining busy cycles.
  logic       m_ex_valid = 1'b0;
  logic [3:0] m_op       = 4'b1001;
  logic       m_ill      = 1'b0;
  logic       m_start    = 1'b0;
  logic [1:0] m_mop      = 2'b00;
  int         m_left     = 0;

  alu_control_mc_if bus ();

  alu_control_mc #(
    .MUL_CYCLES (MUL_L),
    .DIV_CYCLES (DIV_L)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_row(input logic [2:0] aop, input logic any_fn, input logic [5:0] fn,
                         input logic [3:0] code, input logic md, input logic [1:0] mop);
    dec_row_t r;
    r.aop = aop; r.any_fn = any_fn; r.fn = fn; r.code = code; r.md = md; r.mop = mop;
    rows.push_back(r);
  endtask

  task automatic add_vec(input logic [2:0] aop, input logic [5:0] fn);
    vec_t v;
    v.aop = aop; v.fn = fn;
    sweep.push_back(v);
  endtask

  function automatic void model_decode(input logic [2:0] aop, input logic [5:0] fn,
                                       output logic [3:0] code, output logic ill,
                                       output logic md, output logic [1:0] mop);
    code = 4'b1001; ill = 1'b1; md = 1'b0; mop = 2'b00;
    foreach (rows[i]) begin
      if (rows[i].aop == aop && (rows[i].any_fn || rows[i].fn == fn)) begin
        code = rows[i].code; ill = 1'b0; md = rows[i].md; mop = rows[i].mop;
      end
    end
  endfunction

  task automatic model_step();
    logic       busy, rdy, xfer, ill, md;
    logic [3:0] code;
    logic [1:0] mop;
    if (reset) begin
      m_ex_valid = 1'b0; m_op = 4'b1001; m_ill = 1'b0;
      m_start = 1'b0; m_mop = 2'b00; m_left = 0;
    end else begin
      busy = (m_left > 0);
      rdy  = bus.ex_ready && !busy;
      xfer = bus.id_valid && rdy;
      model_decode(bus.alu_op, bus.alu_function, code, ill, md, mop);
      if (bus.ex_ready) begin
        m_ex_valid = xfer;
        if (xfer) begin
          m_op  = code;
          m_ill = ill;
        end
      end
      m_start = 1'b0;
      if (busy) m_left--;
      if (xfer && md) begin
        m_left  = mop[1] ? DIV_L : MUL_L;
        m_start = 1'b1;
        m_mop   = mop;
      end
    end
  endtask

  task automatic compare_outputs();
    check("ex_valid", bus.ex_valid, m_ex_valid);
    check("alu_operation", bus.alu_operation, m_op);
    check("illegal", bus.illegal, m_ill);
    check("md_start", bus.md_start, m_start);
    check("md_busy", bus.md_busy, m_left > 0);
    check("md_done", bus.md_done, m_left == 1);
    check("id_ready", bus.id_ready, bus.ex_ready && !(m_left > 0));
    if (m_left > 0) check("md_op", bus.md_op, m_mop);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      compare_outputs();
    end
  end

  task automatic drive(input logic v, input logic [2:0] aop, input logic [5:0] fn);
    bus.id_valid     = v;
    bus.alu_op       = aop;
    bus.alu_function = fn;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    add_row(3'b111, 1'b0, 6'b100100, 4'b0000, 1'b0, 2'b00);
    add_row(3'b111, 1'b0, 6'b100101, 4'b0001, 1'b0, 2'b00);
    add_row(3'b111, 1'b0, 6'b100111, 4'b0010, 1'b0, 2'b00);
    add_row(3'b111, 1'b0, 6'b100000, 4'b0011, 1'b0, 2'b00);
    add_row(3'b111, 1'b0, 6'b100010, 4'b0100, 1'b0, 2'b00);
    add_row(3'b111, 1'b0, 6'b000010, 4'b0110, 1'b0, 2'b00);
    add_row(3'b111, 1'b0, 6'b000000, 4'b0111, 1'b0, 2'b00);
`ifdef ALU_MULDIV_EN
    add_row(3'b111, 1'b0, 6'b011000, 4'b1010, 1'b1, 2'b00);
    add_row(3'b111, 1'b0, 6'b011001, 4'b1011, 1'b1, 2'b01);
    add_row(3'b111, 1'b0, 6'b011010, 4'b1100, 1'b1, 2'b10);
    add_row(3'b111, 1'b0, 6'b011011, 4'b1101, 1'b1, 2'b11);
`endif
    add_row(3'b001, 1'b1, 6'b000000, 4'b0000, 1'b0, 2'b00);
    add_row(3'b110, 1'b1, 6'b000000, 4'b0011, 1'b0, 2'b00);
    add_row(3'b101, 1'b1, 6'b000000, 4'b0001, 1'b0, 2'b00);
    add_row(3'b010, 1'b1, 6'b000000, 4'b0011, 1'b0, 2'b00);
    add_row(3'b011, 1'b1, 6'b000000, 4'b0101, 1'b0, 2'b00);

    add_vec(3'b111, 6'b100111); add_vec(3'b111, 6'b100010); add_vec(3'b111, 6'b000010);
    add_vec(3'b111, 6'b000000); add_vec(3'b111, 6'b100100); add_vec(3'b111, 6'b100101);
    add_vec(3'b111, 6'b011001); add_vec(3'b010, 6'b111111); add_vec(3'b111, 6'b011011);
    add_vec(3'b110, 6'b011000); add_vec(3'b100, 6'b100000); add_vec(3'b111, 6'b111111);

    // Reset held for two cycles.
    reset = 1'b1;
    bus.ex_ready = 1'b1;
    drive(1'b0, 3'b000, 6'b000000);
    tick(); tick();
    check("rst ex_valid", bus.ex_valid, 1'b0);
    check("rst alu_operation", bus.alu_operation, 4'b1001);
    check("rst illegal", bus.illegal, 1'b0);
    check("rst md_busy", bus.md_busy, 1'b0);
    check("rst md_start", bus.md_start, 1'b0);
    check("rst md_op", bus.md_op, 2'b00);
    check("rst id_ready hi", bus.id_ready, 1'b1);
    bus.ex_ready = 1'b0;
    #1;
    check("rst id_ready lo", bus.id_ready, 1'b0);
    bus.ex_ready = 1'b1;

    // ADD, then ORI and LUI back-to-back.
    reset = 1'b0;
    drive(1'b1, 3'b111, 6'b100000);
    tick();
    check("add ex_valid", bus.ex_valid, 1'b1);
    check("add op", bus.alu_operation, 4'b0011);
    drive(1'b1, 3'b101, 6'b000000);
    tick();
    check("ori op", bus.alu_operation, 4'b0001);
    drive(1'b1, 3'b011, 6'b000000);
    tick();
    check("lui op", bus.alu_operation, 4'b0101);

    // Illegal ALUOp, then ANDI, then idle.
    drive(1'b1, 3'b000, 6'b000000);
    tick();
    check("ill op", bus.alu_operation, 4'b1001);
    check("ill flag", bus.illegal, 1'b1);
    check("ill ex_valid", bus.ex_valid, 1'b1);
    drive(1'b1, 3'b001, 6'b101010);
    tick();
    check("andi op", bus.alu_operation, 4'b0000);
    check("andi illegal", bus.illegal, 1'b0);
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    check("idle ex_valid", bus.ex_valid, 1'b0);

    // MULT followed by a pending ADD.
    drive(1'b1, 3'b111, 6'b011000);
    tick();
`ifdef ALU_MULDIV_EN
    check("mult md_start", bus.md_start, 1'b1);
    check("mult md_op", bus.md_op, 2'b00);
    check("mult md_busy", bus.md_busy, 1'b1);
    check("mult id_ready", bus.id_ready, 1'b0);
    check("mult op", bus.alu_operation, 4'b1010);
`else
    check("mult off op", bus.alu_operation, 4'b1001);
    check("mult off illegal", bus.illegal, 1'b1);
    check("mult off md_busy", bus.md_busy, 1'b0);
`endif
    drive(1'b1, 3'b111, 6'b100000);
    for (int k = 2; k <= 4; k++) begin
      tick();
`ifdef ALU_MULDIV_EN
      check("mult busy", bus.md_busy, 1'b1);
      check("mult hold id_ready", bus.id_ready, 1'b0);
      check("mult start once", bus.md_start, 1'b0);
      check("mult done", bus.md_done, k == 4);
`endif
    end
    tick();
`ifdef ALU_MULDIV_EN
    check("mult after busy", bus.md_busy, 1'b0);
    check("mult after id_ready", bus.id_ready, 1'b1);
`endif
    tick();
    check("add after mult op", bus.alu_operation, 4'b0011);
    check("add after mult valid", bus.ex_valid, 1'b1);

    // Backpressure with SUB pending.
    bus.ex_ready = 1'b0;
    drive(1'b1, 3'b111, 6'b100010);
    repeat (3) begin
      tick();
      check("bp id_ready", bus.id_ready, 1'b0);
      check("bp ex_valid hold", bus.ex_valid, 1'b1);
      check("bp op hold", bus.alu_operation, 4'b0011);
    end
    bus.ex_ready = 1'b1;
    tick();
    check("sub op", bus.alu_operation, 4'b0100);
    check("sub valid", bus.ex_valid, 1'b1);
    drive(1'b0, 3'b000, 6'b000000);
    tick();

    // DIV, then reset during the second busy cycle.
    drive(1'b1, 3'b111, 6'b011010);
    tick();
`ifdef ALU_MULDIV_EN
    check("div md_start", bus.md_start, 1'b1);
    check("div md_op", bus.md_op, 2'b10);
    check("div op", bus.alu_operation, 4'b1100);
`else
    check("div off op", bus.alu_operation, 4'b1001);
    check("div off illegal", bus.illegal, 1'b1);
`endif
    drive(1'b0, 3'b000, 6'b000000);
    tick();
`ifdef ALU_MULDIV_EN
    check("div busy2", bus.md_busy, 1'b1);
`endif
    reset = 1'b1;
    tick();
    check("div rst busy", bus.md_busy, 1'b0);
    check("div rst done", bus.md_done, 1'b0);
    check("div rst op", bus.alu_operation, 4'b1001);
    reset = 1'b0;

    // Decode sweep; ex_ready toggles while any mul/div runs to its fixed latency.
    foreach (sweep[i]) begin
      bus.ex_ready = 1'b1;
      drive(1'b1, sweep[i].aop, sweep[i].fn);
      tick();
      drive(1'b0, 3'b000, 6'b000000);
      bus.ex_ready = i[0];
      for (int w = 0; w < 40 && m_left > 0; w++) tick();
      tick();
    end
    bus.ex_ready = 1'b1;

    // Reset wins over a simultaneous transfer.
    drive(1'b1, 3'b111, 6'b100000);
    reset = 1'b1;
    tick();
    check("rst prio valid", bus.ex_valid, 1'b0);
    check("rst prio op", bus.alu_operation, 4'b1001);
    reset = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_mc.md
# alu_control_mc

Registered, multi-cycle-aware ALU control stage for the MIPS core. Decodes ALUOp plus the R-type function field into the 4-bit ALUOperation code, registers it into the ID/EX boundary with a valid/ready handshake, and sequences MULT/MULTU/DIV/DIVU. For those it issues a start pulse to the multiply/divide datapath, counts its fixed latency, and stalls the front end until the operation completes.

## Interface
- MUL_CYCLES, 32: multiply latency in cycles; must be ≥1.
- DIV_CYCLES, 33: divide latency in cycles; must be ≥1.
- Derived localparam: CNT_W = $clog2(max(MUL_CYCLES, DIV_CYCLES)+1).

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  decode stage presents an operation.
- id_ready  out  1  combinational: ex_ready && !md_busy.
- alu_op  in  3  ALUOp from main control.
- alu_function  in  6  instruction funct field.
- ex_ready  in  1  EX stage can accept.
- ex_valid  out  1  registered: alu_operation is valid.
- alu_operation  out  4  registered ALU operation code.
- illegal  out  1  registered: the decoded op hit the default case.
- md_start  out  1  one-cycle pulse to the mul/div datapath.
- md_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid while md_busy.
- md_busy  out  1  mul/div in progress.
- md_done  out  1  one-cycle pulse in the last busy cycle.

## Operation
- Decode table:
  - ALUOp 111 with funct:
    - AND 100100 → 0000
    - OR 100101 → 0001
    - NOR 100111 → 0010
    - ADD 100000 → 0011
    - SUB 100010 → 0100
    - SRL 000010 → 0110
    - SLL 000000 → 0111
    - MULT 011000 → 1010
    - MULTU 011001 → 1011
    - DIV 011010 → 1100
    - DIVU 011011 → 1101
  - I-type ALUOp (funct ignored): ANDI 001 → 0000; ADDI 110 → 0011; ORI 101 → 0001; SW 010 → 0011; LUI 011 → 0101.
  - Anything else → 1001 with illegal=1.
- Transfer occurs on id_valid && id_ready.
- When ex_ready=1, the output register loads as follows:
  - ex_valid ← transfer.
  - alu_operation and illegal ← decoded values on a transfer; otherwise they hold.
- When ex_ready=0, ex_valid, alu_operation and illegal all hold.
- Illegal ops still produce ex_valid=1; downstream handles the exception.
- FSM states:
  - IDLE: on a transfer of a mul/div op → RUN. Counter loads MUL_CYCLES-1 or DIV_CYCLES-1; md_op is latched.
  - RUN: md_busy=1. Counter decrements each cycle. At count 0, md_done=1 and the next state is IDLE.
- The counter runs independently of ex_ready; the datapath latency is fixed.
- id_ready=0 for the whole of RUN, so new ops are held upstream.

## Timing
- Reset values:
  - ex_valid 0, alu_operation 1001, illegal 0.
  - md_start 0, md_op 00, md_busy 0, md_done 0.
  - Counter 0, state IDLE.
- Latency: a transfer at the edge ending cycle N gives ex_valid and alu_operation in cycle N+1.
- Mul/div transferred at cycle N:
  - md_start is high in cycle N+1 only.
  - md_busy is high in cycles N+1 … N+L, where L = MUL_CYCLES or DIV_CYCLES.
  - md_done is high in cycle N+L.
  - The earliest next transfer is the edge ending cycle N+L+1.
- L=1: md_start, md_busy and md_done are all high in the same single cycle.
- Back-to-back non-mul/div ops sustain one transfer per cycle while ex_ready=1.
- Reset mid-RUN: the next cycle is IDLE with md_busy 0, and no md_done is emitted.
- Reset has priority over a simultaneous transfer.

## Configuration
- ALU_MULDIV_EN defined: full behaviour as above.
- ALU_MULDIV_EN undefined:
  - MULT/MULTU/DIV/DIVU functs decode to 1001 with illegal=1.
  - md_start, md_op, md_busy and md_done are tied 0.
  - id_ready = ex_ready.
  - The FSM and counter are not compiled.

## Structure
- Shared package alu_ctrl_pkg holds:
  - the ALUOp codes, the funct codes and the ALUOperation codes (including the 1001 illegal code);
  - the md_op encoding;
  - the FSM state type.
- Sub-module alu_ctrl_decode: purely combinational. It maps {alu_op, alu_function} to {operation, illegal, is_md, md_op}. The top instantiates it and owns the registers, FSM and counter.

## Test plan
1. Reset held 2 cycles → ex_valid 0, alu_operation 1001, md_busy 0, id_ready equals ex_ready.
2. alu_op 111, funct 100000, id_valid 1, ex_ready 1 → next cycle ex_valid 1, alu_operation 0011. Then ORI (101) and LUI (011) back-to-back → 0001, 0101 on consecutive cycles.
3. alu_op 000 → alu_operation 1001, illegal 1, ex_valid 1. ANDI (001) → 0000, illegal 0.
4. MUL_CYCLES=4, MULT then ADD both presented → md_start 1 cycle with md_op 00, md_busy 4 cycles, md_done on the 4th, id_ready 0 for those 4 cycles. ADD is accepted the next cycle and gives 0011.
5. ex_ready 0 for 3 cycles with SUB pending → id_ready 0 and outputs hold. ex_ready 1 → SUB (0100) is accepted.
6. DIV with DIV_CYCLES=33, reset in busy cycle 2 → md_busy 0 next cycle, no md_done pulse. Same bench compiled without ALU_MULDIV_EN: DIV decodes to 1001 with illegal 1.
